// File: rtl/float_recip_stream.sv
// float_recip_stream
//   Valid/ready wrapper around a free-running, non-stallable reciprocal
//   pipeline. Operands are accepted on the slave port and registered onto
//   recip_in; a matching valid/special-case delay line tracks each operand
//   through the pipeline. When it re-emerges, the IEEE special cases that
//   the magic-number estimate gets wrong are patched, and the result is
//   buffered in a first-word-fall-through FIFO. An occupancy credit counter
//   covering in-flight plus buffered items throttles s_ready, so a result
//   in flight always has a FIFO slot waiting for it.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   s_valid    operand valid
//   s_ready    operand can be accepted (registered state only)
//   s_data     operand x
//   recip_in   operand presented to the reciprocal pipeline (registered)
//   recip_out  pipeline result, LATENCY cycles after recip_in
//   m_valid    result valid
//   m_ready    downstream accepts result
//   m_data     1/x with special-case fix-up
module float_recip_stream #(
    parameter  int unsigned MANTISSA_SIZE = 23,
    parameter  int unsigned LATENCY       = 12,
    parameter  int unsigned FIFO_DEPTH    = 16,
    localparam int unsigned FLOAT_SIZE    = 9 + MANTISSA_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FLOAT_SIZE-1:0] s_data,
    output logic [FLOAT_SIZE-1:0] recip_in,
    input  logic [FLOAT_SIZE-1:0] recip_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FLOAT_SIZE-1:0] m_data
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [FLOAT_SIZE-1:0] INF_MAG = {1'b0, 8'hFF, {MANTISSA_SIZE{1'b0}}};
    localparam logic [FLOAT_SIZE-1:0] QNAN    = {1'b0, 8'hFF, 1'b1, {(MANTISSA_SIZE-1){1'b0}}};

    typedef enum logic [1:0] {
        SC_PASS = 2'd0,
        SC_INF  = 2'd1,
        SC_ZERO = 2'd2,
        SC_NAN  = 2'd3
    } sc_t;

    // ------------------------------------------------------------------
    // Handshake and credit
    // ------------------------------------------------------------------
    logic             alive;
    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             pop;

    // alive rises on the first clock after reset release, holding s_ready
    // low until the reset deassertion has propagated through the flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign s_ready = alive && (occ < OCC_MAX);
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Special-case classification at accept
    // ------------------------------------------------------------------
    logic [7:0]               in_exp;
    logic [MANTISSA_SIZE-1:0] in_man;
    sc_t                      sc_in;

    assign in_exp = s_data[FLOAT_SIZE-2 -: 8];
    assign in_man = s_data[MANTISSA_SIZE-1:0];

    always_comb begin
        sc_in = SC_PASS;
        if (in_exp == 8'h00) begin
            sc_in = SC_INF;
        end else if (in_exp == 8'hFF) begin
            sc_in = (in_man == '0) ? SC_ZERO : SC_NAN;
        end else if (in_exp >= 8'hFD) begin
            sc_in = SC_ZERO;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            recip_in <= '0;
        end else if (accept) begin
            recip_in <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Delay line: LATENCY+1 stages so the tail lines up with recip_out.
    // The operand sign travels with the code so the fixed-up infinities
    // and zeros do not depend on what the estimate did with the sign.
    // ------------------------------------------------------------------
    logic [LATENCY:0] dl_valid;
    logic [LATENCY:0] dl_sign;
    sc_t              dl_code [LATENCY+1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dl_valid <= '0;
            dl_sign  <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                dl_code[i] <= SC_PASS;
            end
        end else begin
            dl_valid   <= {dl_valid[LATENCY-1:0], accept};
            dl_sign    <= {dl_sign[LATENCY-1:0], s_data[FLOAT_SIZE-1]};
            dl_code[0] <= sc_in;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                dl_code[i] <= dl_code[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Fix-up and capture
    // ------------------------------------------------------------------
    logic [FLOAT_SIZE-1:0] fix;
    logic                  cap_valid;
    logic [FLOAT_SIZE-1:0] cap_data;

    always_comb begin
        fix = recip_out;
        case (dl_code[LATENCY])
            SC_INF:  fix = {dl_sign[LATENCY], INF_MAG[FLOAT_SIZE-2:0]};
            SC_ZERO: fix = {dl_sign[LATENCY], {(FLOAT_SIZE-1){1'b0}}};
            SC_NAN:  fix = QNAN;
            default: fix = recip_out;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            cap_valid <= dl_valid[LATENCY];
            if (dl_valid[LATENCY]) begin
                cap_data <= fix;
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO: storage array plus registered head (m_valid/m_data).
    // The credit counter bounds head + storage + capture + in-flight to
    // FIFO_DEPTH, so the storage array cannot overflow.
    // ------------------------------------------------------------------
    logic [FLOAT_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      mem_cnt;
    logic                  mem_empty;
    logic                  head_free;
    logic                  mem_rd;
    logic                  mem_wr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign mem_empty = (mem_cnt == '0);
    assign head_free = !m_valid || m_ready;
    assign mem_rd    = head_free && !mem_empty;
    // The capture stage bypasses storage straight into the head when
    // storage is empty, which keeps pop+write on a one-entry FIFO gapless.
    assign mem_wr    = cap_valid && !(head_free && mem_empty);

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= cap_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({mem_wr, mem_rd})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (head_free) begin
            if (!mem_empty) begin
                m_valid <= 1'b1;
                m_data  <= mem[rd_ptr];
            end else if (cap_valid) begin
                m_valid <= 1'b1;
                m_data  <= cap_data;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
